// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the core's control path (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int PC_W = 9
);
    logic            start;
    logic            stall;
    logic            branch;
    logic [PC_W-1:0] target;
    logic            halt;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            flush;
    logic            busy;
    logic            done;
    logic [15:0]     branch_count;
    logic            stack_err;

    modport master (
        output start, stall, branch, target, halt, call, ret,
        input  pc, fetch_valid, flush, busy, done, branch_count, stack_err
    );

    modport slave (
        input  start, stall, branch, target, halt, call, ret,
        output pc, fetch_valid, flush, busy, done, branch_count, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer / fetch controller: sequential stepping, taken branches with one flush bubble, halt/start.
// Optional return stack for call/ret is built only when CALL_STACK_EN is defined.
module pc_sequencer #(
    parameter int              PC_W        = 9,
    parameter logic [PC_W-1:0] START_ADDR  = '0,
    parameter int              STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     branch_count_q, branch_count_d;
    logic [PC_W-1:0] pc_inc;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pc_inc = pc_q + PC_W'(1);

`ifdef CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0]  sp_q, sp_d;
    logic             stack_err_q, stack_err_d;
    logic [PC_W-1:0]  stack_q [STACK_DEPTH];
    logic             push;
    logic             stack_full, stack_empty;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign wr_idx      = IDX_W'(sp_q);
    assign rd_idx      = IDX_W'(sp_q - SP_W'(1));

    // Return addresses are plain storage; only the pointer needs a reset value.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end
`else
    logic unused_call_ret;
    assign unused_call_ret = bus.call | bus.ret;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            branch_count_q <= '0;
`ifdef CALL_STACK_EN
            sp_q           <= '0;
            stack_err_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            branch_count_q <= branch_count_d;
`ifdef CALL_STACK_EN
            sp_q           <= sp_d;
            stack_err_q    <= stack_err_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        branch_count_d = branch_count_q;
`ifdef CALL_STACK_EN
        sp_d           = sp_q;
        stack_err_d    = stack_err_q;
        push           = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    pc_d           = START_ADDR;
                    branch_count_d = '0;
                    state_d        = S_RUN;
`ifdef CALL_STACK_EN
                    sp_d           = '0;
                    stack_err_d    = 1'b0;
`endif
                end
            end
            S_RUN: begin
                // Upstream holds branch/halt/call/ret across a stall, so nothing is sampled here while stalled.
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_d = S_DONE;
                    end else if (bus.branch) begin
                        pc_d           = bus.target;
                        branch_count_d = sat_inc16(branch_count_q);
                        state_d        = S_FLUSH;
                    end
`ifdef CALL_STACK_EN
                    else if (bus.call) begin
                        if (stack_full) begin
                            pc_d        = pc_inc;
                            stack_err_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            sp_d    = sp_q + SP_W'(1);
                            pc_d    = bus.target;
                            state_d = S_FLUSH;
                        end
                    end else if (bus.ret) begin
                        if (stack_empty) begin
                            pc_d        = pc_inc;
                            stack_err_d = 1'b1;
                        end else begin
                            sp_d    = sp_q - SP_W'(1);
                            pc_d    = stack_q[rd_idx];
                            state_d = S_FLUSH;
                        end
                    end
`endif
                    else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.fetch_valid  = (state_q == S_RUN) && !bus.stall;
    assign bus.flush        = (state_q == S_FLUSH);
    assign bus.busy         = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign bus.done         = (state_q == S_DONE);
    assign bus.branch_count = branch_count_q;
`ifdef CALL_STACK_EN
    assign bus.stack_err    = stack_err_q;
`else
    assign bus.stack_err    = 1'b0;
`endif

endmodule
